// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit:
// operation encodings, sequencer states and default sizes.
package muldiv_pkg;

    localparam int MD_WIDTH = 32;
    localparam int MD_CNT_W = 6;

    typedef enum logic [1:0] {
        MD_MULT  = 2'b00,
        MD_MULTU = 2'b01,
        MD_DIV   = 2'b10,
        MD_DIVU  = 2'b11
    } md_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_FIX  = 2'b10
    } md_state_e;

endpackage

// File: rtl/muldiv_step.sv
// One iteration over the {acc, work} pair: shift-add for multiply,
// restoring trial subtraction for divide.
import muldiv_pkg::*;

module muldiv_step #(
    parameter int WIDTH = MD_WIDTH
) (
    input  logic             i_is_div,
    input  logic [WIDTH-1:0] i_acc,
    input  logic [WIDTH-1:0] i_work,
    input  logic [WIDTH-1:0] i_opnd,
    output logic [WIDTH-1:0] o_acc,
    output logic [WIDTH-1:0] o_work
);

    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_shl;
    logic [WIDTH-1:0] w_diff;
    logic             w_ge;

    // Multiply: conditionally add multiplicand, shift product right.
    assign w_sum  = {1'b0, i_acc} + (i_work[0] ? {1'b0, i_opnd} : '0);

    // Divide: shift next dividend bit into the partial remainder.
    // The difference always fits WIDTH bits when it is kept.
    assign w_shl  = {i_acc, i_work[WIDTH-1]};
    assign w_ge   = (w_shl >= {1'b0, i_opnd});
    assign w_diff = w_shl[WIDTH-1:0] - i_opnd;

    // Select the next accumulator/work pair for the latched op.
    always_comb begin
        o_acc  = '0;
        o_work = '0;
        if (i_is_div) begin
            o_acc  = w_ge ? w_diff : w_shl[WIDTH-1:0];
            o_work = {i_work[WIDTH-2:0], w_ge};
        end else begin
            o_acc  = w_sum[WIDTH:1];
            o_work = {w_sum[0], i_work[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer writing HI/LO.
// Works on magnitudes and fixes signs in a final cycle.
import muldiv_pkg::*;

module muldiv_sequencer #(
    parameter int WIDTH = MD_WIDTH,
    parameter int CNT_W = MD_CNT_W
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] src1_i,
    input  logic [WIDTH-1:0] src2_i,
    input  logic             flush_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    md_state_e          r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_is_div;
    logic               r_neg1;
    logic               r_neg2;
    logic               r_divz;
    logic [WIDTH-1:0]   r_acc;
    logic [WIDTH-1:0]   r_work;
    logic [WIDTH-1:0]   r_opnd;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_done;

    logic               w_div;
    logic               w_sgn;
    logic               w_neg1;
    logic               w_neg2;
    logic [WIDTH-1:0]   w_mag1;
    logic [WIDTH-1:0]   w_mag2;
    logic [WIDTH-1:0]   w_nacc;
    logic [WIDTH-1:0]   w_nwork;
    logic               w_last;
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_prod_fix;
    logic [WIDTH-1:0]   w_quot;
    logic [WIDTH-1:0]   w_rem;
    logic [WIDTH-1:0]   w_hi_fix;
    logic [WIDTH-1:0]   w_lo_fix;

    // Decode the requested op; unsigned ops never see a negative operand.
    assign w_div  = (op_i == MD_DIV) || (op_i == MD_DIVU);
    assign w_sgn  = (op_i == MD_MULT) || (op_i == MD_DIV);
    assign w_neg1 = w_sgn & src1_i[WIDTH-1];
    assign w_neg2 = w_sgn & src2_i[WIDTH-1];
    assign w_mag1 = w_neg1 ? -src1_i : src1_i;
    assign w_mag2 = w_neg2 ? -src2_i : src2_i;

    assign w_last = (r_cnt == CNT_W'(WIDTH - 1));

    muldiv_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .i_is_div (r_is_div),
        .i_acc    (r_acc),
        .i_work   (r_work),
        .i_opnd   (r_opnd),
        .o_acc    (w_nacc),
        .o_work   (w_nwork)
    );

    // Sign correction of the magnitude result.
    // Divide-by-zero forces an all-ones quotient; the remainder path
    // already reproduces the original dividend in that case.
    assign w_prod     = {r_acc, r_work};
    assign w_prod_fix = (r_neg1 ^ r_neg2) ? -w_prod : w_prod;
    assign w_quot     = r_divz ? '1
                      : ((r_neg1 ^ r_neg2) ? -r_work : r_work);
    assign w_rem      = r_neg1 ? -r_acc : r_acc;
    assign w_hi_fix   = r_is_div ? w_rem  : w_prod_fix[2*WIDTH-1:WIDTH];
    assign w_lo_fix   = r_is_div ? w_quot : w_prod_fix[WIDTH-1:0];

    // Sequencer FSM, iteration datapath and HI/LO registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_is_div <= 1'b0;
            r_neg1   <= 1'b0;
            r_neg2   <= 1'b0;
            r_divz   <= 1'b0;
            r_acc    <= '0;
            r_work   <= '0;
            r_opnd   <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (start_i && !flush_i) begin
                        r_state  <= S_RUN;
                        r_cnt    <= '0;
                        r_is_div <= w_div;
                        r_neg1   <= w_neg1;
                        r_neg2   <= w_neg2;
                        r_divz   <= w_div && (src2_i == '0);
                        r_acc    <= '0;
                        r_work   <= w_div ? w_mag1 : w_mag2;
                        r_opnd   <= w_div ? w_mag2 : w_mag1;
                    end
                end
                S_RUN: begin
                    if (flush_i) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_acc  <= w_nacc;
                        r_work <= w_nwork;
                        r_cnt  <= r_cnt + CNT_W'(1);
                        if (w_last) begin
                            r_state <= S_FIX;
                        end
                    end
                end
                S_FIX: begin
                    r_state <= S_IDLE;
                    if (!flush_i) begin
                        r_hi   <= w_hi_fix;
                        r_lo   <= w_lo_fix;
                        r_done <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy_o = (r_state != S_IDLE);
    assign done_o = r_done;
    assign hi_o   = r_hi;
    assign lo_o   = r_lo;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: vector table, random ops
// with a reference model, and hand-written flush/reset/stall sequences.
import muldiv_pkg::*;

module tb_muldiv_sequencer;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         flush;
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    always #5 clk = ~clk;

    muldiv_sequencer dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .start_i (start),
        .op_i    (op),
        .src1_i  (a),
        .src2_i  (b),
        .flush_i (flush),
        .busy_o  (busy),
        .done_o  (done),
        .hi_o    (hi),
        .lo_o    (lo)
    );

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
    } res_t;

    res_t        sb[$];
    vec_t        vecs[12];
    int          tests = 0;
    int          fails = 0;
    logic [31:0] exp_hi = '0;
    logic [31:0] exp_lo = '0;

    task automatic check(string name, logic [63:0] act, logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic res_t model(logic [1:0] o, logic [31:0] x,
                                   logic [31:0] y);
        res_t        r;
        longint      p;
        longint      q;
        longint      m;
        logic [63:0] u;
        r.hi = '0;
        r.lo = '0;
        case (o)
            MD_MULT: begin
                p = longint'($signed(x)) * longint'($signed(y));
                {r.hi, r.lo} = p;
            end
            MD_MULTU: begin
                u = {32'b0, x} * {32'b0, y};
                {r.hi, r.lo} = u;
            end
            MD_DIV: begin
                if (y == 0) begin
                    r.hi = x;
                    r.lo = '1;
                end else begin
                    q = longint'($signed(x)) / longint'($signed(y));
                    m = longint'($signed(x)) % longint'($signed(y));
                    r.lo = q[31:0];
                    r.hi = m[31:0];
                end
            end
            default: begin
                if (y == 0) begin
                    r.hi = x;
                    r.lo = '1;
                end else begin
                    r.lo = x / y;
                    r.hi = x % y;
                end
            end
        endcase
        return r;
    endfunction

    // Issue in the current cycle (DUT idle), follow to completion.
    // inj > 0 pulses a second start at that busy cycle.
    task automatic run_op(string name, logic [1:0] o, logic [31:0] x,
                          logic [31:0] y, res_t e, int inj);
        int   cyc;
        bit   early;
        res_t s;
        op    = o;
        a     = x;
        b     = y;
        start = 1'b1;
        sb.push_back(e);
        tick();
        start = 1'b0;
        cyc   = 0;
        early = 1'b0;
        while (busy && cyc < 100) begin
            if (done) early = 1'b1;
            cyc++;
            if (cyc == inj) begin
                start = 1'b1;
                op    = MD_DIVU;
                a     = 32'h0000DEAD;
                b     = 32'd3;
            end else begin
                start = 1'b0;
            end
            tick();
        end
        start = 1'b0;
        check({name, " busy cycles"}, 64'(cyc), 64'd33);
        check({name, " early done"}, 64'(early), 64'd0);
        check({name, " done pulse"}, 64'(done), 64'd1);
        if (sb.size() > 0) begin
            s = sb.pop_front();
            check({name, " hi"}, 64'(hi), 64'(s.hi));
            check({name, " lo"}, 64'(lo), 64'(s.lo));
            exp_hi = s.hi;
            exp_lo = s.lo;
        end else begin
            check({name, " scoreboard"}, 64'd0, 64'd1);
        end
    endtask

    task automatic watch_quiet(string name, int n);
        int d;
        d = 0;
        repeat (n) begin
            tick();
            if (done || busy) d++;
        end
        check(name, 64'(d), 64'd0);
    endtask

    initial begin
        res_t        r;
        logic [1:0]  ro;
        logic [31:0] ra;
        logic [31:0] rb;

        vecs[0]  = '{MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF,
                     32'hFFFFFFFE, 32'h00000001};
        vecs[1]  = '{MD_MULT,  32'hFFFFFFFD, 32'd5,
                     32'hFFFFFFFF, 32'hFFFFFFF1};
        vecs[2]  = '{MD_DIV,   32'hFFFFFFF9, 32'd2,
                     32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[3]  = '{MD_DIV,   32'h80000000, 32'hFFFFFFFF,
                     32'h00000000, 32'h80000000};
        vecs[4]  = '{MD_DIVU,  32'h00001234, 32'd0,
                     32'h00001234, 32'hFFFFFFFF};
        vecs[5]  = '{MD_DIV,   32'hFFFFFFF9, 32'd0,
                     32'hFFFFFFF9, 32'hFFFFFFFF};
        vecs[6]  = '{MD_MULT,  32'h80000000, 32'h80000000,
                     32'h40000000, 32'h00000000};
        vecs[7]  = '{MD_MULTU, 32'h12345678, 32'h00000010,
                     32'h00000001, 32'h23456780};
        vecs[8]  = '{MD_DIVU,  32'd100, 32'd7,
                     32'h00000002, 32'h0000000E};
        vecs[9]  = '{MD_DIV,   32'd7, 32'hFFFFFFFE,
                     32'h00000001, 32'hFFFFFFFD};
        vecs[10] = '{MD_MULT,  32'd7, 32'hFFFFFFFF,
                     32'hFFFFFFFF, 32'hFFFFFFF9};
        vecs[11] = '{MD_DIVU,  32'hFFFFFFFF, 32'd1,
                     32'h00000000, 32'hFFFFFFFF};

        rst   = 1'b1;
        start = 1'b0;
        flush = 1'b0;
        op    = '0;
        a     = '0;
        b     = '0;
        repeat (2) tick();
        check("reset busy", 64'(busy), 64'd0);
        check("reset done", 64'(done), 64'd0);
        check("reset hi", 64'(hi), 64'd0);
        check("reset lo", 64'(lo), 64'd0);
        rst = 1'b0;

        // Table vectors, issued back to back in each done cycle.
        for (int i = 0; i < 12; i++) begin
            r.hi = vecs[i].hi;
            r.lo = vecs[i].lo;
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a,
                   vecs[i].b, r, 0);
        end

        // MULT then DIV issued in the MULT's done cycle.
        r.hi = 32'hFFFFFFFF;
        r.lo = 32'hFFFFFFF1;
        run_op("b2b mult", MD_MULT, 32'hFFFFFFFD, 32'd5, r, 0);
        check("b2b done cycle busy", 64'(busy), 64'd0);
        r.hi = 32'h00000001;
        r.lo = 32'h00000005;
        run_op("b2b div", MD_DIV, 32'd16, 32'd3, r, 0);

        // Random ops against the reference model.
        for (int i = 0; i < 8; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = (i == 3) ? 32'd0 : $urandom;
            if (i == 5) rb = rb >> 20;
            r  = model(ro, ra, rb);
            run_op($sformatf("rnd%0d", i), ro, ra, rb, r, 0);
        end

        // Flush at cycle 10 of a MULT.
        op    = MD_MULT;
        a     = 32'd5;
        b     = 32'd6;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (9) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush busy", 64'(busy), 64'd0);
        check("flush hi", 64'(hi), 64'(exp_hi));
        check("flush lo", 64'(lo), 64'(exp_lo));
        watch_quiet("flush quiet", 40);
        check("flush hi later", 64'(hi), 64'(exp_hi));

        // Flush together with start in IDLE: op not started.
        op    = MD_MULTU;
        a     = 32'd2;
        b     = 32'd3;
        start = 1'b1;
        flush = 1'b1;
        tick();
        start = 1'b0;
        flush = 1'b0;
        check("flush+start busy", 64'(busy), 64'd0);
        watch_quiet("flush+start quiet", 40);
        check("flush+start lo", 64'(lo), 64'(exp_lo));

        // Start pulsed at cycle 5 of a busy op is dropped.
        r.hi = 32'h0;
        r.lo = 32'd3000000;
        run_op("ignored start", MD_MULTU, 32'd1000, 32'd3000, r, 5);
        watch_quiet("ignored start quiet", 40);
        check("ignored start lo", 64'(lo), 64'd3000000);

        // Reset mid-DIV drops the op and clears HI/LO.
        op    = MD_DIV;
        a     = 32'd100;
        b     = 32'd7;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (10) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst mid busy", 64'(busy), 64'd0);
        check("rst mid done", 64'(done), 64'd0);
        check("rst mid hi", 64'(hi), 64'd0);
        check("rst mid lo", 64'(lo), 64'd0);
        watch_quiet("rst mid quiet", 40);

        check("scoreboard empty", 64'(sb.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
